scatter_hls_deadlock_monitor_unit: RTL

Per-process deadlock monitor, generalised successor of the scatter HLS deadlock detect unit.
- Propagates process-dependency vectors along blocked channels, the same way as the existing unit.
- Adds a configurable confirmation window: a self-dependency must persist for CONFIRM_CYCLES consecutive cycles before a deadlock is declared.
- Captures the set of processes in the cycle, reports it through a valid/ready handshake, and exposes a saturating stall counter.
- One instance per HLS process in the scatter dataflow region.

---
 rtl/scatter_dl_pkg.sv | 25 ++
 rtl/scatter_dl_dep_merge.sv | 22 ++
 rtl/scatter_hls_deadlock_monitor_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/scatter_dl_pkg.sv
// Shared types and helpers for the scatter dataflow deadlock monitor.
package scatter_dl_pkg;

    localparam int MAX_PROC = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        REPORT  = 2'd2,
        HOLD    = 2'd3
    } dl_state_e;

    function automatic logic [MAX_PROC-1:0] onehot(
        input int unsigned id,
        input int unsigned n
    );
        logic [MAX_PROC-1:0] v;
        v = '0;
        if (id < n) begin
            v = {{(MAX_PROC-1){1'b0}}, 1'b1} << id;
        end
        return v;
    endfunction

endpackage

// File: rtl/scatter_dl_dep_merge.sv
// OR-merges the dependency vectors of all valid incoming channels.
module scatter_dl_dep_merge
    import scatter_dl_pkg::*;
#(
    parameter int PROC_NUM    = 4,
    parameter int IN_CHAN_NUM = 2
) (
    input  logic [IN_CHAN_NUM-1:0]          vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] data_vec,
    output logic [PROC_NUM-1:0]             dep_comb
);

    always_comb begin
        dep_comb = '0;
        for (int i = 0; i < IN_CHAN_NUM; i++) begin
            dep_comb = dep_comb
                     | ({PROC_NUM{vld_vec[i]}}
                        & data_vec[i*PROC_NUM +: PROC_NUM]);
        end
    end

endmodule

// File: rtl/scatter_hls_deadlock_monitor_unit.sv
// Per-process deadlock monitor: dependency propagation, confirmation
// window, handshaked cycle report and a saturating stall counter.
module scatter_hls_deadlock_monitor_unit
    import scatter_dl_pkg::*;
#(
    parameter int PROC_NUM       = 4,
    parameter int PROC_ID        = 0,
    parameter int IN_CHAN_NUM    = 2,
    parameter int OUT_CHAN_NUM   = 3,
    parameter int CONFIRM_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
    input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
    input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
    input  logic                            dl_detect_in,
    input  logic                            origin,
    input  logic                            token_clear,
    input  logic                            dl_clear,
    input  logic                            dl_report_ready,
    output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
    output logic [PROC_NUM-1:0]             out_chan_dep_data,
    output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
    output logic                            dl_detect_out,
    output logic                            dl_report_valid,
    output logic [PROC_NUM-1:0]             dl_cycle_vec,
    output logic [CNT_W-1:0]                stall_cnt
);

    localparam logic [MAX_PROC-1:0] OH_FULL = onehot(PROC_ID, PROC_NUM);
    localparam logic [PROC_NUM-1:0] OH      = OH_FULL[PROC_NUM-1:0];
    localparam logic [CNT_W-1:0]    CONF_C  = CNT_W'(CONFIRM_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX = '1;

    if (CONFIRM_CYCLES < 1 || CONFIRM_CYCLES >= (1 << CNT_W)) begin : g_bad_confirm
        $error("CONFIRM_CYCLES must be in 1 .. 2**CNT_W-1");
    end
    if (PROC_ID < 0 || PROC_ID >= PROC_NUM) begin : g_bad_id
        $error("PROC_ID must be in 0 .. PROC_NUM-1");
    end

    logic                blk;
    logic                gate;
    logic                hit;
    logic                enter;
    logic [PROC_NUM-1:0] dep_comb;
    logic [PROC_NUM-1:0] dep;

    dl_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PROC_NUM-1:0]     dep_reg_q, dep_reg_d;
    logic [OUT_CHAN_NUM-1:0] token_q, token_d;
    logic [CNT_W-1:0]        stall_q, stall_d;
    logic                    det_q, det_d;
    logic                    vld_q, vld_d;
    logic [PROC_NUM-1:0]     cyc_q, cyc_d;

    scatter_dl_dep_merge #(
        .PROC_NUM    (PROC_NUM),
        .IN_CHAN_NUM (IN_CHAN_NUM)
    ) u_merge (
        .vld_vec  (in_chan_dep_vld_vec),
        .data_vec (in_chan_dep_data_vec),
        .dep_comb (dep_comb)
    );

    // Once a deadlock is flagged globally, only token-carrying cycles
    // may refresh the dependency view; otherwise the last view is held.
    assign blk  = |proc_dep_vld_vec;
    assign gate = ~dl_detect_in | (|token_in_vec);
    assign dep  = gate ? dep_comb : dep_reg_q;
    assign hit  = gate & dep[PROC_ID] & blk;

    always_comb begin
        dep_reg_d = blk ? dep : '0;
        token_d   = (((|token_in_vec) & ~token_clear) | origin)
                  ? proc_dep_vld_vec : '0;
        stall_d   = '0;
        if (blk) begin
            stall_d = (stall_q == CNT_MAX) ? stall_q : stall_q + CNT_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        det_d   = 1'b0;
        vld_d   = vld_q;
        cyc_d   = cyc_q;
        enter   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    if (CONF_C == CNT_ONE) begin
                        enter = 1'b1;
                    end else begin
                        state_d = CONFIRM;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CONFIRM: begin
                if (!hit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q + CNT_ONE == CONF_C) begin
                    enter = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            REPORT: begin
                if (vld_q && dl_report_ready) begin
                    state_d = HOLD;
                    vld_d   = 1'b0;
                end
            end
            HOLD: begin
                if (!blk) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter) begin
            state_d = REPORT;
            cnt_d   = '0;
            det_d   = 1'b1;
            vld_d   = 1'b1;
            cyc_d   = dep | OH;
        end
        // The captured cycle survives a clear so it can still be inspected.
        if (dl_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            det_d   = 1'b0;
            vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dep_reg_q <= '0;
            token_q   <= '0;
            stall_q   <= '0;
            det_q     <= 1'b0;
            vld_q     <= 1'b0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dep_reg_q <= dep_reg_d;
            token_q   <= token_d;
            stall_q   <= stall_d;
            det_q     <= det_d;
            vld_q     <= vld_d;
            cyc_q     <= cyc_d;
        end
    end

    assign out_chan_dep_vld_vec = proc_dep_vld_vec;
    assign out_chan_dep_data    = dep_reg_q | OH;
    assign token_out_vec        = token_q;
    assign dl_detect_out        = det_q;
    assign dl_report_valid      = vld_q;
    assign dl_cycle_vec         = cyc_q;
    assign stall_cnt            = stall_q;

endmodule
